fifo_wr_ctrl: RTL and testbench
===============================

// Module: fifo_wr_ctrl
// PURPOSE
//   Write-side pointer/flag controller of the async FIFO between the UART and system clock domains.
//   Counterpart of the read-side controller. Owns the binary write pointer and drives the memory write address/enable.
//   Publishes a registered Gray write pointer to the read domain.
//   Synchronises the read domain's Gray pointer and derives the full, almost-full, occupancy and overflow status.
// PARAMETERS
//   ADDR_SIZE     3   memory address width; DEPTH = 2**ADDR_SIZE entries
//   PTR_SIZE      4   pointer width; must equal ADDR_SIZE+1 (wrap bit)
//   SYNC_STAGES   2   flop stages synchronising gray_rd_ptr into w_clk; >=2
//   AFULL_THRESH  6   w_afull asserts when w_level >= AFULL_THRESH; range 1..DEPTH
// PORTS
//   w_clk        in   1          write-domain clock
//   w_rst_n      in   1          async active-low reset
//   w_inc        in   1          write request; data is accepted when w_en=1
//   gray_rd_ptr  in   PTR_SIZE   Gray read pointer from the read domain (async to w_clk)
//   gray_wr_ptr  out  PTR_SIZE   registered Gray write pointer, to the read domain
//   waddr        out  ADDR_SIZE  memory write address = wptr[ADDR_SIZE-1:0]
//   w_en         out  1          memory write enable = w_inc & ~wfull
//   wfull        out  1          FIFO full as seen from the write domain
//   w_afull      out  1          almost full
//   w_level      out  PTR_SIZE   occupancy as seen from the write domain, 0..DEPTH
//   w_ovf        out  1          sticky flag: a write was attempted while full
// BEHAVIOUR
//   - Reset (async, w_rst_n=0):
//     - wptr=0, gray_wr_ptr=0, all sync flops=0, w_ovf=0.
//     - Hence waddr=0, wfull=0, w_afull=0, w_level=0 and w_en=0 (unless w_inc=1).
//     - Takes effect immediately, including mid-write; no pending write survives.
//   - Write pointer: on posedge w_clk with w_en=1:
//     - wptr <= wptr+1, wrapping modulo 2**PTR_SIZE.
//     - gray_wr_ptr <= bin2gray(wptr+1), i.e. (b>>1)^b, on the same edge.
//     - gray_wr_ptr is a flop output only, so it changes exactly one bit per write.
//   - Read-pointer sync: rq = gray_rd_ptr delayed through SYNC_STAGES flops on w_clk.
//     rbin = gray2bin(rq), where b[i] = ^g[PTR_SIZE-1:i].
//   - Flags: decoded combinationally from registered state only (gray_wr_ptr, wptr, rq).
//     There is no combinational path from w_inc or gray_rd_ptr to any flag.
//     - wfull = (gray_wr_ptr == {~rq[PTR_SIZE-1:PTR_SIZE-2], rq[PTR_SIZE-3:0]})
//     - w_level = wptr - rbin, modulo 2**PTR_SIZE; equals DEPTH exactly when wfull=1.
//     - w_afull = (w_level >= AFULL_THRESH).
//   - Latency:
//     - A write is reflected in w_level/wfull on the cycle after its edge.
//     - A read-pointer change is reflected SYNC_STAGES cycles after it is sampled.
//     - Full deassertion is therefore pessimistic by up to SYNC_STAGES+1 w_clk cycles.
//     - Full never deasserts early, so the FIFO can never overwrite unread data.
//   - Write while full: w_en=0, wptr/gray_wr_ptr hold, and w_ovf sets on that edge.
//     w_ovf stays set until reset.
//   - Simultaneous full-release and write: evaluated against the flags of the current cycle.
//     - If wfull=1 this cycle, the write is blocked even if rq changes on the same edge.
//     - A w_inc held high is accepted on the next cycle.
//   - Wrap: wptr 2**PTR_SIZE-1 -> 0 (for 4 bits, gray 1000 -> 0000) and waddr DEPTH-1 -> 0.
//     Wrap is not a full condition on its own.
// TESTING
//   1. Reset with gray_rd_ptr=0000 -> waddr=0, gray_wr_ptr=0000, wfull=0, w_afull=0, w_level=0, w_ovf=0.
//   2. Fill (gray_rd_ptr=0000, w_inc=1 for 10 cycles):
//      - w_en high for 8 cycles, waddr 0..7.
//      - w_afull=1 from w_level=6.
//      - After the 8th write: gray_wr_ptr=1100, w_level=8, wfull=1.
//      - 9th attempt: w_ovf=1, waddr stays 0.
//   3. From full, drive gray_rd_ptr=0001 -> wfull=0 and w_level=7 exactly SYNC_STAGES(2) cycles later.
//      A held w_inc is accepted on the next edge and wfull returns to 1.
//   4. Wrap: move gray_rd_ptr to trail the write pointer by 3 entries while streaming writes.
//      - gray_wr_ptr goes 1000 -> 0000 and waddr goes 7 -> 0.
//      - w_level stays 3 and wfull stays 0 throughout.
//   5. Blocked-then-accepted: wfull=1 and rq updates on the same edge that w_inc=1.
//      - No write on that edge; write accepted one cycle later.
//      - w_ovf=1 from the blocked attempt.
//   6. Assert w_rst_n between clock edges at w_level=5, w_ovf=1 -> all outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer/flag controller of the async FIFO.
// Owns the binary/Gray write pointers, synchronises the read pointer, derives full/level/overflow.
module fifo_wr_ctrl #(
  parameter int unsigned ADDR_SIZE    = 3,
  parameter int unsigned PTR_SIZE     = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned AFULL_THRESH = 6
) (
  input  logic                 w_clk,
  input  logic                 w_rst_n,
  input  logic                 w_inc,
  input  logic [PTR_SIZE-1:0]  gray_rd_ptr,
  output logic [PTR_SIZE-1:0]  gray_wr_ptr,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic                 w_en,
  output logic                 wfull,
  output logic                 w_afull,
  output logic [PTR_SIZE-1:0]  w_level,
  output logic                 w_ovf
);

  localparam logic [PTR_SIZE-1:0] AfullThr = PTR_SIZE'(AFULL_THRESH);

  logic [PTR_SIZE-1:0] wptr_q;
  logic [PTR_SIZE-1:0] gray_q;
  logic                ovf_q;
  logic [PTR_SIZE-1:0] sync_q [SYNC_STAGES];

  logic [PTR_SIZE-1:0] wptr_inc;
  logic [PTR_SIZE-1:0] gray_inc;
  logic [PTR_SIZE-1:0] rq;
  logic [PTR_SIZE-1:0] rbin;

  assign wptr_inc = wptr_q + 1'b1;
  assign gray_inc = (wptr_inc >> 1) ^ wptr_inc;
  assign rq       = sync_q[SYNC_STAGES-1];

  always_comb begin
    rbin = '0;
    for (int i = 0; i < int'(PTR_SIZE); i++) begin
      rbin[i] = ^(rq >> i);
    end
  end

  // Flags depend only on registered state; no path from w_inc or gray_rd_ptr.
  assign wfull   = (gray_q == {~rq[PTR_SIZE-1:PTR_SIZE-2], rq[PTR_SIZE-3:0]});
  assign w_level = wptr_q - rbin;
  assign w_afull = (w_level >= AfullThr);
  assign w_en    = w_inc & ~wfull;

  assign gray_wr_ptr = gray_q;
  assign waddr       = wptr_q[ADDR_SIZE-1:0];
  assign w_ovf       = ovf_q;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      wptr_q <= '0;
      gray_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (w_en) begin
        wptr_q <= wptr_inc;
        gray_q <= gray_inc;
      end
      if (w_inc && wfull) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_rd_ptr;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: table-driven fill plus hand sequences for release, wrap,
// blocked-then-accepted and asynchronous reset.
module tb_fifo_wr_ctrl;

  logic       w_clk = 1'b0;
  logic       w_rst_n;
  logic       w_inc;
  logic [3:0] gray_rd_ptr;
  logic [3:0] gray_wr_ptr;
  logic [2:0] waddr;
  logic       w_en;
  logic       wfull;
  logic       w_afull;
  logic [3:0] w_level;
  logic       w_ovf;

  int checks = 0;
  int errors = 0;

  fifo_wr_ctrl #(
    .ADDR_SIZE   (3),
    .PTR_SIZE    (4),
    .SYNC_STAGES (2),
    .AFULL_THRESH(6)
  ) dut (
    .w_clk      (w_clk),
    .w_rst_n    (w_rst_n),
    .w_inc      (w_inc),
    .gray_rd_ptr(gray_rd_ptr),
    .gray_wr_ptr(gray_wr_ptr),
    .waddr      (waddr),
    .w_en       (w_en),
    .wfull      (wfull),
    .w_afull    (w_afull),
    .w_level    (w_level),
    .w_ovf      (w_ovf)
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    logic       inc;
    logic [3:0] grd;
    logic [2:0] waddr;
    logic [3:0] gwr;
    logic       full;
    logic       afull;
    logic [3:0] lvl;
    logic       ovf;
    logic       en;
  } vec_t;

  vec_t fill_tbl [10];

  function automatic logic [3:0] g(input int unsigned b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] ea, input logic [3:0] eg,
                         input logic ef, input logic eaf, input logic [3:0] el,
                         input logic eo, input logic ee);
    chk({tag, ".waddr"}, 32'(waddr), 32'(ea));
    chk({tag, ".gray_wr_ptr"}, 32'(gray_wr_ptr), 32'(eg));
    chk({tag, ".wfull"}, 32'(wfull), 32'(ef));
    chk({tag, ".w_afull"}, 32'(w_afull), 32'(eaf));
    chk({tag, ".w_level"}, 32'(w_level), 32'(el));
    chk({tag, ".w_ovf"}, 32'(w_ovf), 32'(eo));
    chk({tag, ".w_en"}, 32'(w_en), 32'(ee));
  endtask

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic do_reset();
    w_inc       = 1'b0;
    gray_rd_ptr = 4'b0000;
    w_rst_n     = 1'b0;
    tick();
    tick();
    w_rst_n = 1'b1;
  endtask

  initial begin
    //              inc  grd      waddr gwr      full afull lvl ovf en
    fill_tbl[0] = '{1'b1, 4'b0000, 3'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
    fill_tbl[1] = '{1'b1, 4'b0000, 3'd1, 4'b0001, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1};
    fill_tbl[2] = '{1'b1, 4'b0000, 3'd2, 4'b0011, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1};
    fill_tbl[3] = '{1'b1, 4'b0000, 3'd3, 4'b0010, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1};
    fill_tbl[4] = '{1'b1, 4'b0000, 3'd4, 4'b0110, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1};
    fill_tbl[5] = '{1'b1, 4'b0000, 3'd5, 4'b0111, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1};
    fill_tbl[6] = '{1'b1, 4'b0000, 3'd6, 4'b0101, 1'b0, 1'b1, 4'd6, 1'b0, 1'b1};
    fill_tbl[7] = '{1'b1, 4'b0000, 3'd7, 4'b0100, 1'b0, 1'b1, 4'd7, 1'b0, 1'b1};
    fill_tbl[8] = '{1'b1, 4'b0000, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0, 1'b0};
    fill_tbl[9] = '{1'b1, 4'b0000, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0};

    // Reset state
    do_reset();
    chk_out("reset", 3'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Fill to full and overflow
    for (int i = 0; i < 10; i++) begin
      w_inc       = fill_tbl[i].inc;
      gray_rd_ptr = fill_tbl[i].grd;
      #1;
      chk_out($sformatf("fill%0d", i), fill_tbl[i].waddr, fill_tbl[i].gwr, fill_tbl[i].full,
              fill_tbl[i].afull, fill_tbl[i].lvl, fill_tbl[i].ovf, fill_tbl[i].en);
      tick();
    end

    // Release from full after exactly two sync stages; held w_inc then refills
    gray_rd_ptr = 4'b0001;
    w_inc       = 1'b1;
    #1;
    chk_out("rel0", 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0);
    tick();
    chk_out("rel1", 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0);
    tick();
    chk_out("rel2", 3'd0, 4'b1100, 1'b0, 1'b1, 4'd7, 1'b1, 1'b1);
    tick();
    chk_out("rel3", 3'd1, 4'b1101, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0);

    // Wrap with the read pointer trailing by three entries
    do_reset();
    for (int w = 0; w < 20; w++) begin
      w_inc       = 1'b1;
      gray_rd_ptr = g(unsigned'(w + 15));
      #1;
      if (w >= 2) begin
        chk_out($sformatf("wrap%0d", w), 3'(w % 8), g(unsigned'(w)), 1'b0, 1'b0, 4'd3,
                1'b0, 1'b1);
      end
      tick();
    end

    // Blocked on the edge where rq changes, accepted one cycle later
    do_reset();
    w_inc = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    w_inc       = 1'b0;
    gray_rd_ptr = 4'b0001;
    #1;
    chk_out("blk0", 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0, 1'b0);
    tick();
    w_inc = 1'b1;
    #1;
    chk_out("blk1", 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0, 1'b0);
    tick();
    chk_out("blk2", 3'd0, 4'b1100, 1'b0, 1'b1, 4'd7, 1'b1, 1'b1);
    tick();
    w_inc = 1'b0;
    #1;
    chk_out("blk3", 3'd1, 4'b1101, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0);

    // Asynchronous reset between edges at level 5 with overflow set
    gray_rd_ptr = g(4);
    tick();
    tick();
    chk_out("pre_rst", 3'd1, 4'b1101, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
    #1;
    w_rst_n = 1'b0;
    #1;
    chk_out("async_rst", 3'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    w_inc = 1'b1;
    #1;
    chk("async_rst.w_en_follows_inc", 32'(w_en), 32'd1);
    w_inc = 1'b0;
    w_rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
